// File: rtl/cs_sequencer.sv
// Microprogram sequencer: owns the control-store address register (CSAR) and selects the
// next microinstruction address each cycle (increment, conditional/unconditional jump, or
// instruction decode). Stalls while a memory access requested by the current microword
// is outstanding.
// Optional feature macro: CS_SEQUENCER_TIMEOUT_EN (WAIT-state watchdog that traps to
// TRAP_ADDRESS and sets a sticky TIMEOUT flag).
module cs_sequencer #(
   parameter int unsigned                CSAI_DATAWIDTH = 11,
   parameter int unsigned                TIMEOUT_CYCLES = 64,
   parameter logic [CSAI_DATAWIDTH-1:0]  TRAP_ADDRESS   = 11'h7F0
) (
   input  logic                      CS_SEQUENCER_CLOCK_50,
   input  logic                      CS_SEQUENCER_RESET_InHigh,
   input  logic                      CS_SEQUENCER_START_In,
   input  logic [2:0]                CS_SEQUENCER_COND_InBus,
   input  logic [CSAI_DATAWIDTH-1:0] CS_SEQUENCER_JUMPADDR_InBus,
   input  logic [1:0]                CS_SEQUENCER_IROP_InBus,
   input  logic [5:0]                CS_SEQUENCER_IROP3_InBus,
   input  logic                      CS_SEQUENCER_IR13_In,
   input  logic [3:0]                CS_SEQUENCER_FLAGS_InBus,
   input  logic                      CS_SEQUENCER_MEMREQ_In,
   input  logic                      CS_SEQUENCER_MEMACK_In,
   output logic [CSAI_DATAWIDTH-1:0] CS_SEQUENCER_CSAddress_OutBus,
   output logic                      CS_SEQUENCER_STALL_Out,
   output logic [1:0]                CS_SEQUENCER_STATE_OutBus,
   output logic                      CS_SEQUENCER_TIMEOUT_Out
);

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StRun  = 2'b01,
      StWait = 2'b10,
      StTrap = 2'b11
   } state_e;

   localparam logic [CSAI_DATAWIDTH-1:0] CsarOne = {{(CSAI_DATAWIDTH-1){1'b0}}, 1'b1};

   state_e                    state_q, state_d;
   logic [CSAI_DATAWIDTH-1:0] csar_q, csar_d;
   logic [CSAI_DATAWIDTH-1:0] next_addr;
   logic [CSAI_DATAWIDTH-1:0] csar_inc;
   logic [10:0]               decode_addr;
   logic                      flag_n, flag_z, flag_v, flag_c;
   logic                      mem_stall;

`ifdef CS_SEQUENCER_TIMEOUT_EN
   localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

   logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
   logic            timeout_q, timeout_d;
`else
   // Watchdog parameters only matter when the timeout feature is built in.
   logic unused_cfg;
   assign unused_cfg = ^{TRAP_ADDRESS, TIMEOUT_CYCLES};
`endif

   assign {flag_n, flag_z, flag_v, flag_c} = CS_SEQUENCER_FLAGS_InBus;
   assign mem_stall = CS_SEQUENCER_MEMREQ_In & ~CS_SEQUENCER_MEMACK_In;

   // Next-address select from the current microword COND field.
   always_comb begin
      csar_inc    = csar_q + CsarOne;
      decode_addr = {1'b1, CS_SEQUENCER_IROP_InBus, CS_SEQUENCER_IROP3_InBus, 2'b00};
      next_addr   = csar_inc;
      case (CS_SEQUENCER_COND_InBus)
         3'b000:  next_addr = csar_inc;
         3'b001:  next_addr = flag_n ? CS_SEQUENCER_JUMPADDR_InBus : csar_inc;
         3'b010:  next_addr = flag_z ? CS_SEQUENCER_JUMPADDR_InBus : csar_inc;
         3'b011:  next_addr = flag_v ? CS_SEQUENCER_JUMPADDR_InBus : csar_inc;
         3'b100:  next_addr = flag_c ? CS_SEQUENCER_JUMPADDR_InBus : csar_inc;
         3'b101:  next_addr = CS_SEQUENCER_IR13_In ? CS_SEQUENCER_JUMPADDR_InBus : csar_inc;
         3'b110:  next_addr = CS_SEQUENCER_JUMPADDR_InBus;
         default: next_addr = CSAI_DATAWIDTH'(decode_addr);
      endcase
   end

   // Sequencer FSM next-state and CSAR update.
   always_comb begin
      state_d = state_q;
      csar_d  = csar_q;
`ifdef CS_SEQUENCER_TIMEOUT_EN
      wait_cnt_d = wait_cnt_q;
      timeout_d  = timeout_q;
`endif
      case (state_q)
         StIdle: begin
            csar_d = '0;
            if (CS_SEQUENCER_START_In) begin
               state_d = StRun;
            end
         end
         StRun, StTrap: begin
            // TRAP sequences exactly like RUN; only the reported state code differs.
            if (mem_stall) begin
               state_d = StWait;
`ifdef CS_SEQUENCER_TIMEOUT_EN
               wait_cnt_d = '0;
`endif
            end else begin
               csar_d = next_addr;
            end
         end
         StWait: begin
            // An ACK on the final watchdog cycle still wins over the trap.
            if (CS_SEQUENCER_MEMACK_In) begin
               csar_d  = next_addr;
               state_d = StRun;
`ifdef CS_SEQUENCER_TIMEOUT_EN
            end else if (wait_cnt_q == CntLast) begin
               csar_d    = TRAP_ADDRESS;
               timeout_d = 1'b1;
               state_d   = StTrap;
            end else begin
               wait_cnt_d = wait_cnt_q + CntW'(1);
`endif
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State registers with synchronous active-high reset.
   always_ff @(posedge CS_SEQUENCER_CLOCK_50) begin
      if (CS_SEQUENCER_RESET_InHigh) begin
         state_q <= StIdle;
         csar_q  <= '0;
`ifdef CS_SEQUENCER_TIMEOUT_EN
         wait_cnt_q <= '0;
         timeout_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         csar_q  <= csar_d;
`ifdef CS_SEQUENCER_TIMEOUT_EN
         wait_cnt_q <= wait_cnt_d;
         timeout_q  <= timeout_d;
`endif
      end
   end

   assign CS_SEQUENCER_CSAddress_OutBus = csar_q;
   assign CS_SEQUENCER_STALL_Out        = (state_q == StWait);
   assign CS_SEQUENCER_STATE_OutBus     = state_q;
`ifdef CS_SEQUENCER_TIMEOUT_EN
   assign CS_SEQUENCER_TIMEOUT_Out = timeout_q;
`else
   assign CS_SEQUENCER_TIMEOUT_Out = 1'b0;
`endif

endmodule

// File: tb/tb_cs_sequencer.sv
// Scoreboard bench for cs_sequencer: stimulus pushes the expected post-edge CSAR/state/
// stall/timeout into a queue; a monitor pops and compares one entry per clock.
module tb_cs_sequencer;

   localparam logic [1:0] S_IDLE = 2'b00;
   localparam logic [1:0] S_RUN  = 2'b01;
   localparam logic [1:0] S_WAIT = 2'b10;
   localparam logic [1:0] S_TRAP = 2'b11;

   logic        clk = 1'b0;
   logic        rst, start, ir13, memreq, memack;
   logic [2:0]  cond;
   logic [10:0] jump;
   logic [1:0]  irop;
   logic [5:0]  irop3;
   logic [3:0]  flags;
   logic [10:0] csar;
   logic        stall, timeout;
   logic [1:0]  state;

   typedef struct {
      logic [10:0] csar;
      logic [1:0]  state;
      logic        stall;
      logic        timeout;
      string       name;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   cs_sequencer #(
      .CSAI_DATAWIDTH (11),
      .TIMEOUT_CYCLES (8),
      .TRAP_ADDRESS   (11'h7F0)
   ) dut (
      .CS_SEQUENCER_CLOCK_50         (clk),
      .CS_SEQUENCER_RESET_InHigh     (rst),
      .CS_SEQUENCER_START_In         (start),
      .CS_SEQUENCER_COND_InBus       (cond),
      .CS_SEQUENCER_JUMPADDR_InBus   (jump),
      .CS_SEQUENCER_IROP_InBus       (irop),
      .CS_SEQUENCER_IROP3_InBus      (irop3),
      .CS_SEQUENCER_IR13_In          (ir13),
      .CS_SEQUENCER_FLAGS_InBus      (flags),
      .CS_SEQUENCER_MEMREQ_In        (memreq),
      .CS_SEQUENCER_MEMACK_In        (memack),
      .CS_SEQUENCER_CSAddress_OutBus (csar),
      .CS_SEQUENCER_STALL_Out        (stall),
      .CS_SEQUENCER_STATE_OutBus     (state),
      .CS_SEQUENCER_TIMEOUT_Out      (timeout)
   );

   // Drive one cycle of inputs and queue the expected outputs after the next rising edge.
   task automatic step(input logic r, input logic s, input logic [2:0] c, input logic [10:0] j,
                       input logic [3:0] f, input logic i13, input logic [1:0] op,
                       input logic [5:0] op3, input logic rq, input logic ak,
                       input logic [10:0] e_csar, input logic [1:0] e_state,
                       input logic e_stall, input logic e_to, input string name);
      exp_t e;
      @(negedge clk);
      rst = r; start = s; cond = c; jump = j; flags = f; ir13 = i13;
      irop = op; irop3 = op3; memreq = rq; memack = ak;
      e.csar = e_csar; e.state = e_state; e.stall = e_stall; e.timeout = e_to; e.name = name;
      sb_q.push_back(e);
      @(posedge clk);
   endtask

   // Monitor: compare one queued expectation per clock, away from the edge.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         checks++;
         if (csar !== e.csar || state !== e.state || stall !== e.stall ||
             timeout !== e.timeout) begin
            errors++;
            $display("FAIL %s: got csar=%h state=%b stall=%b to=%b, want csar=%h state=%b stall=%b to=%b",
                     e.name, csar, state, stall, timeout, e.csar, e.state, e.stall, e.timeout);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got hang, want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; start = 1'b0; cond = 3'b000; jump = '0; flags = '0; ir13 = 1'b0;
      irop = '0; irop3 = '0; memreq = 1'b0; memack = 1'b0;

      step(1, 0, 3'b000, 11'h000, 4'b0000, 0, 2'b00, 6'h00, 0, 0, 11'h000, S_IDLE, 0, 0, "reset");
      step(0, 1, 3'b000, 11'h000, 4'b0000, 0, 2'b00, 6'h00, 0, 0, 11'h000, S_RUN, 0, 0, "start");
      for (int i = 1; i <= 4; i++)
         step(0, 0, 3'b000, 11'h000, 4'b0000, 0, 2'b00, 6'h00, 0, 0, 11'(i), S_RUN, 0, 0, "inc");
      step(0, 0, 3'b000, 11'h000, 4'b0000, 0, 2'b00, 6'h00, 0, 0, 11'h005, S_RUN, 0, 0, "inc5");
      step(0, 0, 3'b010, 11'h123, 4'b0100, 0, 2'b00, 6'h00, 0, 0, 11'h123, S_RUN, 0, 0, "z_taken");
      step(0, 0, 3'b110, 11'h005, 4'b0000, 0, 2'b00, 6'h00, 0, 0, 11'h005, S_RUN, 0, 0, "jump");
      step(0, 0, 3'b010, 11'h123, 4'b0000, 0, 2'b00, 6'h00, 0, 0, 11'h006, S_RUN, 0, 0, "z_not");
      step(0, 0, 3'b111, 11'h123, 4'b0000, 0, 2'b10, 6'h00, 0, 0, 11'h600, S_RUN, 0, 0, "decode_a");
      step(0, 0, 3'b111, 11'h123, 4'b0000, 0, 2'b11, 6'h04, 0, 0, 11'h710, S_RUN, 0, 0, "decode_b");
      step(0, 0, 3'b001, 11'h0AA, 4'b1000, 0, 2'b00, 6'h00, 0, 0, 11'h0AA, S_RUN, 0, 0, "n_taken");
      step(0, 0, 3'b011, 11'h123, 4'b1000, 0, 2'b00, 6'h00, 0, 0, 11'h0AB, S_RUN, 0, 0, "v_not");
      step(0, 0, 3'b100, 11'h055, 4'b0001, 0, 2'b00, 6'h00, 0, 0, 11'h055, S_RUN, 0, 0, "c_taken");
      step(0, 0, 3'b101, 11'h009, 4'b0000, 1, 2'b00, 6'h00, 0, 0, 11'h009, S_RUN, 0, 0, "ir13");
      // Memory stall: three cycles with ACK low, then ACK.
      step(0, 0, 3'b000, 11'h000, 4'b0000, 0, 2'b00, 6'h00, 1, 0, 11'h009, S_WAIT, 1, 0, "wait1");
      step(0, 0, 3'b000, 11'h000, 4'b0000, 0, 2'b00, 6'h00, 1, 0, 11'h009, S_WAIT, 1, 0, "wait2");
      step(0, 1, 3'b000, 11'h000, 4'b0000, 0, 2'b00, 6'h00, 1, 0, 11'h009, S_WAIT, 1, 0, "wait3");
      step(0, 0, 3'b000, 11'h000, 4'b0000, 0, 2'b00, 6'h00, 1, 1, 11'h00A, S_RUN, 0, 0, "ack");
      step(0, 0, 3'b000, 11'h000, 4'b0000, 0, 2'b00, 6'h00, 1, 1, 11'h00B, S_RUN, 0, 0, "req_ack");
      step(0, 1, 3'b000, 11'h000, 4'b0000, 0, 2'b00, 6'h00, 0, 1, 11'h00C, S_RUN, 0, 0, "ign_start");
      // Address wrap.
      step(0, 0, 3'b110, 11'h7FF, 4'b0000, 0, 2'b00, 6'h00, 0, 0, 11'h7FF, S_RUN, 0, 0, "to_7ff");
      step(0, 0, 3'b000, 11'h000, 4'b0000, 0, 2'b00, 6'h00, 0, 0, 11'h000, S_RUN, 0, 0, "wrap");
      // Reset in the middle of a WAIT.
      step(0, 0, 3'b000, 11'h000, 4'b0000, 0, 2'b00, 6'h00, 0, 0, 11'h001, S_RUN, 0, 0, "inc_a");
      step(0, 0, 3'b000, 11'h000, 4'b0000, 0, 2'b00, 6'h00, 1, 0, 11'h001, S_WAIT, 1, 0, "wait_r");
      step(1, 0, 3'b000, 11'h000, 4'b0000, 0, 2'b00, 6'h00, 1, 0, 11'h000, S_IDLE, 0, 0, "rst_wait");
      step(0, 0, 3'b110, 11'h123, 4'b0000, 0, 2'b00, 6'h00, 0, 0, 11'h000, S_IDLE, 0, 0, "idle_ign");
      step(0, 1, 3'b110, 11'h123, 4'b0000, 0, 2'b00, 6'h00, 0, 0, 11'h000, S_RUN, 0, 0, "start2");
      step(0, 0, 3'b000, 11'h000, 4'b0000, 0, 2'b00, 6'h00, 0, 0, 11'h001, S_RUN, 0, 0, "inc_b");
      // Long stall: eight WAIT cycles with no ACK.
      for (int k = 0; k < 8; k++)
         step(0, 0, 3'b000, 11'h000, 4'b0000, 0, 2'b00, 6'h00, 1, 0, 11'h001, S_WAIT, 1, 0,
              "long_wait");
`ifdef CS_SEQUENCER_TIMEOUT_EN
      step(0, 0, 3'b000, 11'h000, 4'b0000, 0, 2'b00, 6'h00, 1, 0, 11'h7F0, S_TRAP, 0, 1, "trap");
      step(0, 0, 3'b000, 11'h000, 4'b0000, 0, 2'b00, 6'h00, 0, 0, 11'h7F1, S_TRAP, 0, 1, "trap_seq");
`else
      for (int k = 0; k < 4; k++)
         step(0, 0, 3'b000, 11'h000, 4'b0000, 0, 2'b00, 6'h00, 1, 0, 11'h001, S_WAIT, 1, 0,
              "no_timeout");
      step(0, 0, 3'b000, 11'h000, 4'b0000, 0, 2'b00, 6'h00, 1, 1, 11'h002, S_RUN, 0, 0, "late_ack");
`endif

      // Let the monitor drain the queue, bounded.
      for (int n = 0; n < 5 && sb_q.size() > 0; n++) @(negedge clk);
      if (sb_q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain: got %0d pending expectations, want 0", sb_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cs_sequencer.md
Name: cs_sequencer

Overview:
- Microprogram sequencer for the microcoded control unit: owns the control-store address register (CSAR) and selects the next microinstruction address every cycle.
- Next-address sources: CSAR+1 (increment path), a jump address from the current microword, or a decode address built from the instruction register.
- Stalls the microprogram while a memory access requested by the current microword is outstanding.
- Sits between the control store (microword fields in) and the control-store ROM address port (CSAR out).

Parameters:
- CSAI_DATAWIDTH, 11, control-store address width; decode address format below requires exactly 11.
- TIMEOUT_CYCLES, 64, WAIT-state cycle limit, used only with the optional feature.
- TRAP_ADDRESS, 11'h7F0, microcode trap entry, used only with the optional feature.

Ports:
- CS_SEQUENCER_CLOCK_50  in  1  system clock; all state changes on rising edge.
- CS_SEQUENCER_RESET_InHigh  in  1  synchronous, active-high reset (one clock; reset is synchronous and active-high).
- CS_SEQUENCER_START_In  in  1  leave IDLE and begin executing microcode at address 0.
- CS_SEQUENCER_COND_InBus  in  3  microword COND field.
- CS_SEQUENCER_JUMPADDR_InBus  in  CSAI_DATAWIDTH  microword jump address.
- CS_SEQUENCER_IROP_InBus  in  2  IR[31:30].
- CS_SEQUENCER_IROP3_InBus  in  6  IR[24:19].
- CS_SEQUENCER_IR13_In  in  1  IR[13].
- CS_SEQUENCER_FLAGS_InBus  in  4  PSR flags {n,z,v,c}.
- CS_SEQUENCER_MEMREQ_In  in  1  current microword issues a memory read/write.
- CS_SEQUENCER_MEMACK_In  in  1  memory access complete.
- CS_SEQUENCER_CSAddress_OutBus  out  CSAI_DATAWIDTH  CSAR, drives control-store address.
- CS_SEQUENCER_STALL_Out  out  1  high while in WAIT.
- CS_SEQUENCER_STATE_OutBus  out  2  IDLE=00, RUN=01, WAIT=10, TRAP=11.
- CS_SEQUENCER_TIMEOUT_Out  out  1  sticky timeout flag; constant 0 without the optional feature.

Behaviour:
- Reset: CSAR=0, state=IDLE, STALL=0, TIMEOUT=0, internal wait counter=0. Reset has priority over every other event, including mid-WAIT.
- Next-address select (combinational, from the current microword):
  - 000: CSAR+1
  - 001: n ? JUMP : CSAR+1
  - 010: z ? JUMP : CSAR+1
  - 011: v ? JUMP : CSAR+1
  - 100: c ? JUMP : CSAR+1
  - 101: IR13 ? JUMP : CSAR+1
  - 110: JUMP
  - 111: decode = {1'b1, IROP[1:0], IROP3[5:0], 2'b00}
- CSAR+1 is computed modulo 2^CSAI_DATAWIDTH: 11'h7FF+1 = 11'h000, no flag.
- IDLE: CSAR held at 0; microword inputs are ignored. START=1 -> RUN, CSAR stays 0.
- RUN: each cycle CSAR <= next-address (1-cycle registered latency).
  - MEMREQ=1 and MEMACK=0: go to WAIT; CSAR held.
  - MEMREQ=1 and MEMACK=1 in the same cycle: advance normally, stay in RUN.
  - MEMREQ=0: MEMACK is ignored.
- WAIT: CSAR held; STALL=1; microword fields remain valid because CSAR is unchanged.
  - MEMACK=1: CSAR <= next-address evaluated in that cycle (flags sampled then), go to RUN, STALL drops the following cycle.
  - START is ignored outside IDLE.
- TRAP: unreachable without the optional feature.

Optional Feature:
- Macro: CS_SEQUENCER_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT and clears on entering WAIT.
  - If it reaches TIMEOUT_CYCLES with no ACK: CSAR <= TRAP_ADDRESS, TIMEOUT <= 1 (sticky until reset), state -> TRAP.
  - TRAP behaves as RUN (sequencing continues from TRAP_ADDRESS) but reports state code 11.
  - An ACK arriving on the timeout cycle wins: normal advance, no trap.
- Undefined: no counter; WAIT lasts indefinitely; TIMEOUT tied to 0.

Test Plan:
- Reset then START, COND=000 for 4 cycles -> CSAR 0,1,2,3,4; STATE 00 -> 01.
- CSAR=5, COND=010, JUMP=11'h123, z=1 -> CSAR=11'h123 next cycle; repeat with z=0 -> CSAR=6.
- COND=111, IROP=2'b10, IROP3=6'b000000 -> CSAR=11'h600; IROP=2'b11, IROP3=6'b000100 -> CSAR=11'h710.
- CSAR=9, MEMREQ=1, MEMACK low 3 cycles then high -> CSAR holds 9 with STALL=1 for 3 cycles, then 10; same-cycle REQ+ACK -> no stall.
- CSAR=11'h7FF, COND=000 -> CSAR=0; RESET asserted during WAIT -> next cycle CSAR=0, IDLE, STALL=0.
- With CS_SEQUENCER_TIMEOUT_EN and TIMEOUT_CYCLES=8: hold MEMACK=0 -> after 8 WAIT cycles CSAR=11'h7F0, TIMEOUT=1, STATE=11; without the macro -> stall persists, TIMEOUT=0.
